// File: rtl/mips_harvard_data_mem.sv
// rtl/mips_harvard_data_mem.sv - Harvard data-memory responder with clear sweep, sticky error and access counters
// Word RAM in one address window; illegal requests flag a sticky error and never touch memory.
module mips_harvard_data_mem #(
   parameter int          ADDR_W         = 10,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter bit          CLEAR_ON_RESET = 1'b0,
   parameter string       INIT_FILE      = ""
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clock_enable,
   input  logic [31:0]       data_address,
   input  logic              data_read,
   input  logic              data_write,
   input  logic [31:0]       data_writedata,
   output logic [31:0]       data_readdata,
   output logic              ready,
   output logic              error,
   output logic [31:0]       error_addr,
   output logic [15:0]       read_count,
   output logic [15:0]       write_count,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [31:0]       dbg_rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      S_CLEAR = 1'b0,
      S_READY = 1'b1
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [31:0]       r_mem [DEPTH];
   logic [ADDR_W-1:0] r_clr_idx;
   logic              r_error;
   logic [31:0]       r_error_addr;
   logic [15:0]       r_read_count;
   logic [15:0]       r_write_count;

   logic [ADDR_W-1:0] w_idx;
   logic              w_hit;
   logic              w_aligned;
   logic              w_ready;
   logic              w_legal;
   logic              w_legal_rd;
   logic              w_legal_wr;
   logic              w_illegal;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_waddr;
   logic [31:0]       w_mem_wdata;

   assign w_idx      = data_address[ADDR_W+1:2];
   assign w_hit      = (data_address[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
   assign w_aligned  = (data_address[1:0] == 2'b00);
   assign w_ready    = (r_state == S_READY);
   assign w_legal    = w_hit && w_aligned && (data_read ^ data_write) && w_ready && !reset;
   assign w_legal_rd = w_legal && data_read;
   assign w_legal_wr = w_legal && data_write;
   assign w_illegal  = (data_read || data_write) && !w_legal;

   assign data_readdata = w_legal_rd ? r_mem[w_idx] : 32'h0;
   assign dbg_rdata     = r_mem[dbg_addr];
   assign ready         = w_ready;
   assign error         = r_error;
   assign error_addr    = r_error_addr;
   assign read_count    = r_read_count;
   assign write_count   = r_write_count;

   // The clear sweep and CPU writes share the single RAM write port.
   always_comb begin
      w_next_state = r_state;
      w_mem_we     = 1'b0;
      w_mem_waddr  = w_idx;
      w_mem_wdata  = data_writedata;
      case (r_state)
         S_CLEAR: begin
            w_mem_we    = 1'b1;
            w_mem_waddr = r_clr_idx;
            w_mem_wdata = 32'h0;
            if (&r_clr_idx) begin
               w_next_state = S_READY;
            end
         end
         S_READY: begin
            w_mem_we = w_legal_wr && clock_enable;
         end
         default: begin
            w_next_state = S_READY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
         r_clr_idx <= '0;
      end else begin
         r_state <= w_next_state;
         if (r_state == S_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset && w_mem_we) begin
         r_mem[w_mem_waddr] <= w_mem_wdata;
      end
   end

   // error_addr only captures the request that first raised the flag.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_error      <= 1'b0;
         r_error_addr <= 32'h0;
      end else if (w_illegal && clock_enable && !r_error) begin
         r_error      <= 1'b1;
         r_error_addr <= data_address;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_read_count  <= 16'h0;
         r_write_count <= 16'h0;
      end else if (clock_enable) begin
         if (w_legal_rd && (r_read_count != 16'hFFFF)) begin
            r_read_count <= r_read_count + 16'h1;
         end
         if (w_legal_wr && (r_write_count != 16'hFFFF)) begin
            r_write_count <= r_write_count + 16'h1;
         end
      end
   end

endmodule
